// File: rtl/ltc5548_sys_pio_edge_irq_pkg.sv
// Shared constants for the PIO edge-capture block: register word addresses and parameter limits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ltc5548_sys_pio_edge_irq_pkg;

    // Word addresses of the register map; 1 and 7 are holes that read as zero.
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_DBNC    = 3'd6;

    // Legal ranges of the top-level parameters.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int DB_W_MIN  = 1;
    localparam int DB_W_MAX  = 16;

endpackage

// File: rtl/ltc5548_sys_pio_dbnc_bit.sv
// One input bit: 2-flop synchroniser, saturating debounce counter, rise/fall detect on the debounced level.
// Latency: a step sampled by sync1 at edge k updates stable at edge k+2+dbnc; rise/fall are valid after that edge.
// Backpressure: none, processes one sample per clock.
// Ports: clk/reset_n; in_bit asynchronous input; dbnc extra cycles of agreement required;
//        stable debounced level; rise/fall single-cycle edge strobes.
module ltc5548_sys_pio_dbnc_bit
    import ltc5548_sys_pio_edge_irq_pkg::*;
#(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_bit,
    input  logic [DB_W-1:0] dbnc,
    output logic            stable,
    output logic            rise,
    output logic            fall
);

    logic            sync1;
    logic            sync2;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= in_bit;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt >= dbnc) begin
                // cnt earlier disagreeing cycles plus this one reach dbnc+1.
                // '>=' keeps this correct if dbnc is lowered while a count is running.
                stable <= sync2;
                cnt    <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

endmodule

// File: rtl/ltc5548_sys_pio_edge_irq.sv
// Memory-mapped PIO: debounced inputs, per-bit rise/fall edge capture (W1C) and a masked level interrupt.
// Latency: readdata one clock after address; input step to EDGECAP set is 3+DBNC clocks; irq combinational from EDGECAP.
// Backpressure: none, the slave accepts a write or read every clock.
// Ports: clk/reset_n; address/chipselect/write_n/writedata slave bus; in_port async inputs;
//        readdata registered read data; irq level interrupt.
module ltc5548_sys_pio_edge_irq #(
    parameter int WIDTH = 8,
    parameter int DB_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    import ltc5548_sys_pio_edge_irq_pkg::*;

    logic             wr_en;
    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [DB_W-1:0]  dbnc;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Upper writedata bits have no storage when WIDTH or DB_W is narrower than the bus.
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ltc5548_sys_pio_dbnc_bit #(
            .DB_W (DB_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .dbnc    (dbnc),
            .stable  (stable_vec[i]),
            .rise    (rise_vec[i]),
            .fall    (fall_vec[i])
        );
    end

    assign cap_set = (rise_en & rise_vec) | (fall_en & fall_vec);
    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edgecap  <= '0;
            rise_en  <= '1;
            fall_en  <= '0;
            dbnc     <= '0;
        end else begin
            // Clear is applied after set so software never loses a clear to a racing edge.
            edgecap <= (edgecap | cap_set) & ~cap_clr;
            if (wr_en) begin
                case (address)
                    ADDR_IRQMASK: irq_mask <= writedata[WIDTH-1:0];
                    ADDR_RISE_EN: rise_en  <= writedata[WIDTH-1:0];
                    ADDR_FALL_EN: fall_en  <= writedata[WIDTH-1:0];
                    ADDR_DBNC:    dbnc     <= writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(stable_vec);
            ADDR_IRQMASK: rd_mux = 32'(irq_mask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            ADDR_RISE_EN: rd_mux = 32'(rise_en);
            ADDR_FALL_EN: rd_mux = 32'(fall_en);
            ADDR_DBNC:    rd_mux = 32'(dbnc);
            default:      rd_mux = '0;
        endcase
    end

    // Loaded every clock regardless of chipselect: fixed one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap & irq_mask);

endmodule

// File: doc/ltc5548_sys_pio_edge_irq.md
LTC5548_SYS_PIO_EDGE_IRQ -- requirements
Module: ltc5548_sys_pio_edge_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, input bit count (1..32).
REQ-002 SHALL have parameter DB_W, default 16, debounce counter and DBNC register width (1..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port address, input, 3, word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port in_port, input, WIDTH, asynchronous external inputs.
REQ-010 SHALL have port readdata, output, 32, registered read data.
REQ-011 SHALL have port irq, output, 1, level interrupt.

Function
REQ-012 Register map: 0 DATA (RO, debounced level); 2 IRQMASK (RW); 3 EDGECAP (W1C); 4 RISE_EN (RW); 5 FALL_EN (RW); 6 DBNC (RW, DB_W bits).
REQ-013 Addresses 1 and 7 SHALL read 0 and ignore writes; register bits above WIDTH (or DB_W) SHALL read 0.
REQ-014 Write = chipselect & ~write_n, taking effect on that clock edge; reads have no side effects.
REQ-015 readdata SHALL load the mux for the current address on every clock edge, regardless of chipselect (fixed read latency 1).
REQ-016 Each in_port bit SHALL pass a 2-flop synchroniser (sync1, sync2).
REQ-017 Per bit: while sync2 != stable, cnt increments; when sync2 has differed for DBNC+1 consecutive cycles, stable <= sync2 and cnt <= 0.
REQ-018 Per bit: sync2 == stable SHALL clear cnt; cnt SHALL saturate and never wrap.
REQ-019 DBNC = 0 SHALL give stable <= sync2 every cycle; a DBNC write takes effect immediately and SHALL NOT clear counters.
REQ-020 stable_d <= stable each cycle.
REQ-021 Edge detection: rise = stable & ~stable_d; fall = ~stable & stable_d.
REQ-022 EDGECAP[i] SHALL be set when (RISE_EN[i] & rise[i]) | (FALL_EN[i] & fall[i]).
REQ-023 A write to EDGECAP with writedata[i] = 1 SHALL clear bit i; a clear SHALL win over a same-cycle edge on that bit.
REQ-024 Step-to-capture latency: a step first sampled by sync1 at edge k SHALL set EDGECAP at edge k+3+DBNC.
REQ-025 irq SHALL be the combinational OR-reduce of (EDGECAP & IRQMASK), with no additional register stage.
REQ-026 A pulse shorter than DBNC+1 cycles after synchronisation SHALL be rejected with no change to stable.

Reset
REQ-027 On reset_n low, immediately: readdata, sync1, sync2, stable, stable_d, cnt, EDGECAP, IRQMASK, FALL_EN, DBNC = 0; RISE_EN = all ones; irq = 0.
REQ-028 An input held high through reset SHALL produce one rising capture after release; this is the required behaviour.
REQ-029 Reset mid-debounce SHALL abandon the count with no capture.

Structure
REQ-030 A shared package SHALL hold the register address constants (ADDR_DATA .. ADDR_DBNC) and the WIDTH/DB_W limits.
REQ-031 Per-bit synchroniser + debounce + edge logic SHALL be one sub-module, ltc5548_sys_pio_dbnc_bit, instantiated WIDTH times via generate.

Verification
REQ-032 DBNC=0, RISE_EN=0xFF: in_port 0x00->0x01 -> EDGECAP=0x01 at k+3; irq stays 0 (IRQMASK=0).
REQ-033 IRQMASK=0x01, FALL_EN=0x01, RISE_EN=0: in_port[0] 1->0 -> EDGECAP=0x01, irq=1; write 0x01 to addr 3 -> EDGECAP=0, irq=0.
REQ-034 DBNC=4: 3-cycle glitch on in_port[2] -> no capture; 6-cycle high -> DATA=0x04 and EDGECAP[2]=1 at k+7.
REQ-035 EDGECAP clear coinciding with a new rising edge on the same bit -> bit reads 0 afterwards; a different bit's edge in the same cycle is still captured.
REQ-036 WIDTH=32: read addr 1 -> 0; write 0xFFFF_FFFF to DBNC -> reads 0x0000_FFFF; reset asserted mid-debounce -> all registers at reset values, no capture after release.
